mpu_alu_seq: RTL and testbench
==============================

MPU_ALU_SEQ -- requirements
Module: mpu_alu_seq

Interface
REQ-001 Parameter: DAT_TIMEOUT, default 255, idle cycles allowed in LOAD before abort; 0 disables the timeout.
REQ-002 sys_clk  in  1  single clock; all state updates on the rising edge.
REQ-003 sys_rst  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-005 cmd_op  in  4  op code: 0 none, 1 mask, 2 masked-equal, 3 less-than.
REQ-006 cmd_size  in  2  operand size: 0=8, 1=16, 2=32, 3=64 bits.
REQ-007 dat_valid / dat_ready  in / out  1 / 1  operand-word handshake.
REQ-008 dat  in  32  operand word.
REQ-009 alu_op, alu_size, alu_a, alu_b, alu_m0, alu_m1  out  4, 2, 64, 64, 64, 64  drive to the ALU.
REQ-010 alu_res  in  64  ALU result; only bit 0 is used.
REQ-011 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-012 rsp_res, rsp_err  out  1, 1  boolean result and error flag.

Function
REQ-013 States: IDLE, LOAD, EXEC, RESP.
REQ-014 cmd_ready SHALL be 1 only in IDLE.
- A command is accepted on cmd_valid&&cmd_ready.
- On acceptance, op and size are latched and the a, b, m0 and m1 registers are cleared to 0.
REQ-015 Operand set per op, loaded in this order:
- op1: a, m0, m1
- op2: a, b, m0
- op3: a, b
- op0: none
REQ-016 Words per operand:
- size 3: two words, low word first, then high word.
- sizes 0-2: one word, truncated to the size width and zero-extended to 64 bits.
REQ-017 dat_ready SHALL be 1 only in LOAD; a word is consumed on dat_valid&&dat_ready.
REQ-018 Accepted op 1-3 SHALL go to LOAD; op0 SHALL go directly to EXEC.
- Op greater than 3 SHALL go directly to RESP with rsp_err=1 and rsp_res=0.
REQ-019 LOAD SHALL go to EXEC in the cycle after the last required word is consumed.
REQ-020 EXEC SHALL last exactly one cycle.
- alu_op and alu_size carry the latched values.
- alu_a, alu_b, alu_m0 and alu_m1 carry the operand registers.
- At the end of EXEC, alu_res[0] is registered into rsp_res (0 for op0), rsp_err=0, and the state goes to RESP.
REQ-021 Outside EXEC, alu_op SHALL be 0.
- alu_size and the operand outputs hold their register values.
REQ-022 rsp_valid SHALL be 1 exactly in RESP.
- rsp_res and rsp_err stay stable while rsp_valid=1.
- On rsp_ready=1 the state returns to IDLE the next cycle.
REQ-023 Latency:
- Last data word consumed in cycle N -> EXEC in N+1 -> rsp_valid=1 in N+2.
- op0: command accepted in cycle N -> rsp_valid=1 in N+2.
REQ-024 A new command SHALL NOT be accepted in the cycle rsp_ready completes a response; earliest acceptance is the following cycle.
REQ-025 Timeout counter:
- Resets to 0 on entering LOAD and on every consumed word.
- Increments each LOAD cycle without a transfer.
- When it reaches DAT_TIMEOUT (nonzero): go to RESP with rsp_err=1 and rsp_res=0; the pending word is not consumed.
REQ-026 dat_valid outside LOAD and cmd_valid outside IDLE SHALL be ignored (not consumed).
REQ-027 Word counter width SHALL cover the maximum of 6 words; the counter does not wrap within a command.

Reset
REQ-028 While sys_rst=1, and at any point including mid-LOAD or mid-RESP, the outputs SHALL immediately be:
- state=IDLE, cmd_ready=1, dat_ready=0
- rsp_valid=0, rsp_res=0, rsp_err=0
- alu_op=0, alu_size=0, all alu operand outputs=0
- word and timeout counters=0
REQ-029 After sys_rst deasserts, the first command SHALL be acceptable on the first rising edge.

Verification
REQ-030 op2, size0; words 0x1234, 0x5634, 0x00FF -> a=0x34, b=0x34, m0=0xFF; rsp_valid 2 cycles after the 3rd word; rsp_res=1, rsp_err=0.
REQ-031 op3, size3; words 5, 0, 0, 1 -> a=5, b=0x1_0000_0000, rsp_res=1; during EXEC alu_op=3 and alu_size=3.
REQ-032 op1, size1; words 0x00FF, 0xFF00, 0x00FF -> rsp_res=1; repeat with m1=0x007F -> rsp_res=0.
REQ-033 op5 -> no dat_ready, rsp_valid 1 cycle later with rsp_err=1, rsp_res=0; hold rsp_ready=0 for 10 cycles -> outputs stable.
REQ-034 op2 with only 1 word sent, DAT_TIMEOUT=4 -> rsp_err=1 after 4 idle LOAD cycles; separately, assert sys_rst mid-LOAD -> the REQ-028 values appear with no clock edge, then a fresh command completes normally.

Source files
------------

// File: rtl/mpu_alu_seq.sv
// mpu_alu_seq -- command sequencer for the MPU comparison ALU.
//
// Accepts a command (op, size), collects the operand words that op needs over
// the dat handshake, drives the external ALU for exactly one EXEC cycle,
// registers bit 0 of its result and presents it on the rsp handshake.
//
// Ports
//   sys_clk, sys_rst             clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_op[3:0], cmd_size[1:0]   op code (0 none, 1 mask, 2 masked-equal,
//                                3 less-than) and operand size (8/16/32/64)
//   dat_valid/dat_ready, dat     operand-word handshake (ready only in LOAD)
//   alu_op, alu_size             to ALU; alu_op is nonzero only in EXEC
//   alu_a, alu_b, alu_m0, alu_m1 operand registers to ALU
//   alu_res[63:0]                ALU result, only bit 0 is used
//   rsp_valid/rsp_ready          response handshake (valid only in RESP)
//   rsp_res, rsp_err             boolean result and error flag
module mpu_alu_seq #(
  parameter int DAT_TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [1:0]  cmd_size,
  input  logic        dat_valid,
  output logic        dat_ready,
  input  logic [31:0] dat,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_size,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [63:0] alu_m0,
  output logic [63:0] alu_m1,
  input  logic [63:0] alu_res,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_res,
  output logic        rsp_err
);

  localparam int TW = (DAT_TIMEOUT > 0) ? $clog2(DAT_TIMEOUT + 1) : 1;
  // Counter value in the last idle cycle before the timeout fires.
  localparam logic [TW-1:0] TMO_LAST = TW'(DAT_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  size_q, size_d;
  logic [63:0] a_q, a_d, b_q, b_d, m0_q, m0_d, m1_q, m1_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        rsp_res_q, rsp_res_d, rsp_err_q, rsp_err_d;

  logic [2:0]  n_words_s;
  logic [1:0]  opnd_idx_s;
  logic [1:0]  slot_s;       // 0=a, 1=b, 2=m0, 3=m1
  logic        hi_s;
  logic [63:0] old_s, new_s;

  // Only bit 0 of the ALU result carries information.
  logic unused_alu_res;
  assign unused_alu_res = ^alu_res[63:1];

  // Words to load for the latched op/size, and which operand/half the
  // current word belongs to.
  always_comb begin
    n_words_s  = 3'd0;
    opnd_idx_s = (size_q == 2'd3) ? wcnt_q[2:1] : wcnt_q[1:0];
    hi_s       = (size_q == 2'd3) && wcnt_q[0];
    slot_s     = 2'd0;
    case (op_q)
      4'd1: begin
        n_words_s = (size_q == 2'd3) ? 3'd6 : 3'd3;
        case (opnd_idx_s)
          2'd0:    slot_s = 2'd0;
          2'd1:    slot_s = 2'd2;
          default: slot_s = 2'd3;
        endcase
      end
      4'd2: begin
        n_words_s = (size_q == 2'd3) ? 3'd6 : 3'd3;
        case (opnd_idx_s)
          2'd0:    slot_s = 2'd0;
          2'd1:    slot_s = 2'd1;
          default: slot_s = 2'd2;
        endcase
      end
      4'd3: begin
        n_words_s = (size_q == 2'd3) ? 3'd4 : 3'd2;
        slot_s    = (opnd_idx_s == 2'd0) ? 2'd0 : 2'd1;
      end
      default: begin
        n_words_s = 3'd0;
        slot_s    = 2'd0;
      end
    endcase
  end

  // Merge the incoming word into the selected operand register: 64-bit
  // operands fill low half then high half, narrower ones are truncated.
  always_comb begin
    case (slot_s)
      2'd0:    old_s = a_q;
      2'd1:    old_s = b_q;
      2'd2:    old_s = m0_q;
      default: old_s = m1_q;
    endcase
    case (size_q)
      2'd0:    new_s = {56'd0, dat[7:0]};
      2'd1:    new_s = {48'd0, dat[15:0]};
      2'd2:    new_s = {32'd0, dat};
      default: new_s = hi_s ? {dat, old_s[31:0]} : {old_s[63:32], dat};
    endcase
  end

  // Next-state and register update logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    size_d    = size_q;
    a_d       = a_q;
    b_d       = b_q;
    m0_d      = m0_q;
    m1_d      = m1_q;
    wcnt_d    = wcnt_q;
    tmo_d     = tmo_q;
    rsp_res_d = rsp_res_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d      = cmd_op;
          size_d    = cmd_size;
          a_d       = 64'd0;
          b_d       = 64'd0;
          m0_d      = 64'd0;
          m1_d      = 64'd0;
          wcnt_d    = 3'd0;
          tmo_d     = '0;
          rsp_res_d = 1'b0;
          rsp_err_d = 1'b0;
          if (cmd_op == 4'd0) begin
            state_d = S_EXEC;
          end else if (cmd_op <= 4'd3) begin
            state_d = S_LOAD;
          end else begin
            state_d   = S_RESP;
            rsp_err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (dat_valid) begin
          tmo_d = '0;
          case (slot_s)
            2'd0:    a_d  = new_s;
            2'd1:    b_d  = new_s;
            2'd2:    m0_d = new_s;
            default: m1_d = new_s;
          endcase
          if (wcnt_q == n_words_s - 3'd1) begin
            state_d = S_EXEC;
          end else begin
            wcnt_d = wcnt_q + 3'd1;
          end
        end else if ((DAT_TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          state_d   = S_RESP;
          rsp_res_d = 1'b0;
          rsp_err_d = 1'b1;
        end else if (DAT_TIMEOUT != 0) begin
          tmo_d = tmo_q + 1'b1;
        end else begin
          tmo_d = tmo_q;
        end
      end
      S_EXEC: begin
        rsp_res_d = (op_q == 4'd0) ? 1'b0 : alu_res[0];
        rsp_err_d = 1'b0;
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      op_q      <= 4'd0;
      size_q    <= 2'd0;
      a_q       <= 64'd0;
      b_q       <= 64'd0;
      m0_q      <= 64'd0;
      m1_q      <= 64'd0;
      wcnt_q    <= 3'd0;
      tmo_q     <= '0;
      rsp_res_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      size_q    <= size_d;
      a_q       <= a_d;
      b_q       <= b_d;
      m0_q      <= m0_d;
      m1_q      <= m1_d;
      wcnt_q    <= wcnt_d;
      tmo_q     <= tmo_d;
      rsp_res_q <= rsp_res_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign dat_ready = (state_q == S_LOAD);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_res   = rsp_res_q;
  assign rsp_err   = rsp_err_q;
  assign alu_op    = (state_q == S_EXEC) ? op_q : 4'd0;
  assign alu_size  = size_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_m0    = m0_q;
  assign alu_m1    = m1_q;

endmodule

// File: tb/tb_mpu_alu_seq.sv
// Directed testbench for mpu_alu_seq (DAT_TIMEOUT=4). A small ALU model
// answers the sequencer: op1 (a & ~m0) == m1, op2 (a & m0) == (b & m0),
// op3 a < b, anything else 1 (so a result that ought to be 0 is exposed).
module tb_mpu_alu_seq;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [1:0]  cmd_size;
  logic        dat_valid, dat_ready;
  logic [31:0] dat;
  logic [3:0]  alu_op;
  logic [1:0]  alu_size;
  logic [63:0] alu_a, alu_b, alu_m0, alu_m1, alu_res;
  logic        rsp_valid, rsp_ready, rsp_res, rsp_err;

  int n_checks = 0;
  int n_pass   = 0;

  mpu_alu_seq #(.DAT_TIMEOUT(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_size(cmd_size),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat(dat),
    .alu_op(alu_op), .alu_size(alu_size),
    .alu_a(alu_a), .alu_b(alu_b), .alu_m0(alu_m0), .alu_m1(alu_m1),
    .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_err(rsp_err)
  );

  always #5 sys_clk = ~sys_clk;

  always_comb begin
    alu_res = 64'd0;
    case (alu_op)
      4'd1:    alu_res[0] = ((alu_a & ~alu_m0) == alu_m1);
      4'd2:    alu_res[0] = ((alu_a & alu_m0) == (alu_b & alu_m0));
      4'd3:    alu_res[0] = (alu_a < alu_b);
      default: alu_res[0] = 1'b1;
    endcase
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [1:0] sz);
    cmd_op    = op;
    cmd_size  = sz;
    cmd_valid = 1'b1;
    check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    dat       = w;
    dat_valid = 1'b1;
    check("dat_ready_load", {63'd0, dat_ready}, 64'd1);
    check("alu_op_load", {60'd0, alu_op}, 64'd0);
    tick();
    dat_valid = 1'b0;
  endtask

  task automatic check_exec(input logic [3:0] op, input logic [1:0] sz,
                            input logic [63:0] a, b, m0, m1);
    check("exec_alu_op", {60'd0, alu_op}, {60'd0, op});
    check("exec_alu_size", {62'd0, alu_size}, {62'd0, sz});
    check("exec_alu_a", alu_a, a);
    check("exec_alu_b", alu_b, b);
    check("exec_alu_m0", alu_m0, m0);
    check("exec_alu_m1", alu_m1, m1);
    check("exec_rsp_valid", {63'd0, rsp_valid}, 64'd0);
  endtask

  task automatic check_resp(input logic res, input logic err);
    check("resp_valid", {63'd0, rsp_valid}, 64'd1);
    check("resp_res", {63'd0, rsp_res}, {63'd0, res});
    check("resp_err", {63'd0, rsp_err}, {63'd0, err});
    check("resp_alu_op", {60'd0, alu_op}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("resp_done_idle", {62'd0, cmd_ready, rsp_valid}, 64'd2);
  endtask

  initial begin
    sys_rst   = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 4'd0;
    cmd_size  = 2'd0;
    dat_valid = 1'b0;
    dat       = 32'd0;
    rsp_ready = 1'b0;
    #12;
    check("rst_handshakes", {61'd0, cmd_ready, dat_ready, rsp_valid}, 64'd4);
    check("rst_rsp", {62'd0, rsp_res, rsp_err}, 64'd0);
    check("rst_alu_a", alu_a, 64'd0);
    tick();
    sys_rst = 1'b0;

    // op2 size0: masked-equal on truncated bytes, latency N+1 EXEC / N+2 RESP
    send_cmd(4'd2, 2'd0);
    send_word(32'h0000_1234);
    send_word(32'h0000_5634);
    send_word(32'h0000_00FF);
    check_exec(4'd2, 2'd0, 64'h34, 64'h34, 64'hFF, 64'd0);
    tick();
    check_resp(1'b1, 1'b0);

    // op3 size3: two-word operands, low word first
    send_cmd(4'd3, 2'd3);
    send_word(32'd5);
    send_word(32'd0);
    send_word(32'd0);
    send_word(32'd1);
    check_exec(4'd3, 2'd3, 64'd5, 64'h1_0000_0000, 64'd0, 64'd0);
    tick();
    check_resp(1'b1, 1'b0);

    // op1 size1: mask true, then mask false (upper bits of a word dropped)
    send_cmd(4'd1, 2'd1);
    send_word(32'h0000_00FF);
    send_word(32'h0000_FF00);
    send_word(32'h0000_00FF);
    check_exec(4'd1, 2'd1, 64'hFF, 64'd0, 64'hFF00, 64'hFF);
    tick();
    check_resp(1'b1, 1'b0);
    send_cmd(4'd1, 2'd1);
    send_word(32'hABCD_00FF);
    send_word(32'h0000_FF00);
    send_word(32'h0000_007F);
    check_exec(4'd1, 2'd1, 64'hFF, 64'd0, 64'hFF00, 64'h7F);
    tick();
    check_resp(1'b0, 1'b0);

    // op5: straight to RESP with error; held for 10 cycles, data ignored
    send_cmd(4'd5, 2'd2);
    dat_valid = 1'b1;
    dat       = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      check("op5_hold", {60'd0, rsp_valid, rsp_res, rsp_err, dat_ready}, 64'hA);
      tick();
    end
    dat_valid = 1'b0;
    // completing a response while cmd_valid is high must not accept it
    cmd_op    = 4'd0;
    cmd_size  = 2'd0;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("no_accept_on_complete", {62'd0, cmd_ready, rsp_valid}, 64'd2);
    tick();
    cmd_valid = 1'b0;
    check("op0_exec", {58'd0, cmd_ready, rsp_valid, alu_op}, 64'd0);
    tick();
    check_resp(1'b0, 1'b0);

    // timeout: one word of three, then 4 idle LOAD cycles
    send_cmd(4'd2, 2'd0);
    send_word(32'h11);
    for (int i = 0; i < 4; i++) begin
      check("tmo_wait", {62'd0, dat_ready, rsp_valid}, 64'd2);
      tick();
    end
    check_resp(1'b0, 1'b1);

    // asynchronous reset mid-LOAD
    send_cmd(4'd3, 2'd3);
    send_word(32'd5);
    send_word(32'd0);
    check("pre_rst_alu_a", alu_a, 64'd5);
    #3;
    sys_rst = 1'b1;
    #1;
    check("arst_handshakes", {61'd0, cmd_ready, dat_ready, rsp_valid}, 64'd4);
    check("arst_rsp", {62'd0, rsp_res, rsp_err}, 64'd0);
    check("arst_alu_ctl", {58'd0, alu_op, alu_size}, 64'd0);
    check("arst_alu_ops", alu_a | alu_b | alu_m0 | alu_m1, 64'd0);
    tick();
    sys_rst = 1'b0;

    // fresh command after reset, size2 zero-extension
    send_cmd(4'd3, 2'd2);
    send_word(32'hFFFF_FFFE);
    send_word(32'hFFFF_FFFF);
    check_exec(4'd3, 2'd2, 64'hFFFF_FFFE, 64'hFFFF_FFFF, 64'd0, 64'd0);
    tick();
    check_resp(1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
